// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: bus widths, source
// encodings and the internal grant enumeration.
package cdb_arbiter_pkg;

    // Bus widths shared with the rest of the core
    localparam int ROBBus  = 4;
    localparam int DataBus = 32;
    localparam int ROB_W   = ROBBus;
    localparam int DATA_W  = DataBus;

    // cdb_src encoding seen by the snoopers
    localparam logic CDB_SRC_ALU = 1'b0;
    localparam logic CDB_SRC_LSB = 1'b1;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;
    localparam logic True    = 1'b1;
    localparam logic False   = 1'b0;

    // Outcome of one arbitration cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LSB  = 2'd2
    } grant_e;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source skid FIFO. Holds results that lost arbitration so the producer
// never has to stall mid-flight. Flush has priority over push/pop; a push
// into a full FIFO is silently refused (the parent flags it).
module cdb_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full
);
    import cdb_arbiter_pkg::*;

    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] PONE_C  = PW'(1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_r;

    logic          push_ok_s;
    logic          pop_ok_s;
    logic [CW-1:0] count_nxt_s;

    // Qualify push/pop against occupancy and compute next occupancy
    always_comb begin
        push_ok_s   = push && (count_r < DEPTH_C);
        pop_ok_s    = pop && (count_r != ZERO_C);
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = ZERO_C;
        end else if (push_ok_s && !pop_ok_s) begin
            count_nxt_s = count_r + ONE_C;
        end else if (!push_ok_s && pop_ok_s) begin
            count_nxt_s = count_r - ONE_C;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointer, occupancy and registered full flag; pointers wrap modulo depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= ZERO_C;
            full_r   <= False;
        end else begin
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == DEPTH_C);
            if (flush) begin
                rd_ptr_r <= {PW{1'b0}};
                wr_ptr_r <= {PW{1'b0}};
            end else begin
                if (push_ok_s) begin
                    wr_ptr_r <= wr_ptr_r + PONE_C;
                end
                if (pop_ok_s) begin
                    rd_ptr_r <= rd_ptr_r + PONE_C;
                end
            end
        end
    end

    // Storage array, written at the tail on an accepted push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_r;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: merges ALU and LSB results onto one registered
// broadcast. Each source offers its FIFO head, or its live input when the
// FIFO is empty (zero-latency bypass). Collisions resolve round-robin and
// the loser's live input is parked in its FIFO.
module cdb_arbiter #(
    parameter int ROB_W      = cdb_arbiter_pkg::ROBBus,
    parameter int DATA_W     = cdb_arbiter_pkg::DataBus,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              alu_valid,
    input  logic [ROB_W-1:0]  alu_rob,
    input  logic [DATA_W-1:0] alu_value,
    output logic              alu_full,
    input  logic              lsb_valid,
    input  logic [ROB_W-1:0]  lsb_rob,
    input  logic [DATA_W-1:0] lsb_value,
    output logic              lsb_full,
    output logic              cdb_valid,
    output logic              cdb_src,
    output logic [ROB_W-1:0]  cdb_rob,
    output logic [DATA_W-1:0] cdb_value,
    output logic              overflow
);
    import cdb_arbiter_pkg::*;

    localparam int W  = ROB_W + DATA_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [W-1:0]  alu_din_s, lsb_din_s;
    logic [W-1:0]  alu_head_s, lsb_head_s;
    logic [CW-1:0] alu_count_s, lsb_count_s;
    logic          alu_full_s, lsb_full_s;
    logic          alu_empty_s, lsb_empty_s;
    logic          alu_cand_s, lsb_cand_s;
    logic          contention_s;
    logic          live_s, flush_s;
    logic          alu_push_s, lsb_push_s;
    logic          alu_pop_s, lsb_pop_s;
    logic          ovf_set_s;
    logic [W-1:0]  win_s;
    grant_e        grant_s;

    logic              rr_r;
    logic              cdb_valid_r;
    logic              cdb_src_r;
    logic [ROB_W-1:0]  cdb_rob_r;
    logic [DATA_W-1:0] cdb_value_r;
    logic              overflow_r;

    assign alu_din_s = {alu_rob, alu_value};
    assign lsb_din_s = {lsb_rob, lsb_value};

    // Candidate selection, round-robin grant and FIFO push/pop decisions
    always_comb begin
        alu_empty_s  = (alu_count_s == {CW{1'b0}});
        lsb_empty_s  = (lsb_count_s == {CW{1'b0}});
        alu_cand_s   = !alu_empty_s || alu_valid;
        lsb_cand_s   = !lsb_empty_s || lsb_valid;
        contention_s = alu_cand_s && lsb_cand_s;
        live_s       = rdy && !clr;
        flush_s      = rdy && clr;
        grant_s      = GNT_NONE;
        win_s        = {W{1'b0}};

        case ({alu_cand_s, lsb_cand_s})
            2'b10:   grant_s = GNT_ALU;
            2'b01:   grant_s = GNT_LSB;
            2'b11:   grant_s = rr_r ? GNT_LSB : GNT_ALU;
            default: grant_s = GNT_NONE;
        endcase

        case (grant_s)
            GNT_ALU: win_s = alu_empty_s ? alu_din_s : alu_head_s;
            GNT_LSB: win_s = lsb_empty_s ? lsb_din_s : lsb_head_s;
            default: win_s = {W{1'b0}};
        endcase

        // A live input bypasses only when its FIFO is empty and it wins
        alu_pop_s  = live_s && (grant_s == GNT_ALU) && !alu_empty_s;
        lsb_pop_s  = live_s && (grant_s == GNT_LSB) && !lsb_empty_s;
        alu_push_s = live_s && alu_valid && !((grant_s == GNT_ALU) && alu_empty_s);
        lsb_push_s = live_s && lsb_valid && !((grant_s == GNT_LSB) && lsb_empty_s);
        ovf_set_s  = (alu_push_s && alu_full_s) || (lsb_push_s && lsb_full_s);
    end

    cdb_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_s),
        .push  (alu_push_s),
        .pop   (alu_pop_s),
        .din   (alu_din_s),
        .head  (alu_head_s),
        .count (alu_count_s),
        .full  (alu_full_s)
    );

    cdb_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_s),
        .push  (lsb_push_s),
        .pop   (lsb_pop_s),
        .din   (lsb_din_s),
        .head  (lsb_head_s),
        .count (lsb_count_s),
        .full  (lsb_full_s)
    );

    // Broadcast registers and round-robin pointer; frozen while rdy is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_r        <= 1'b0;
            cdb_valid_r <= False;
            cdb_src_r   <= CDB_SRC_ALU;
            cdb_rob_r   <= {ROB_W{1'b0}};
            cdb_value_r <= {DATA_W{1'b0}};
        end else if (rdy) begin
            if (clr) begin
                rr_r        <= 1'b0;
                cdb_valid_r <= False;
            end else begin
                if (contention_s) begin
                    rr_r <= ~rr_r;
                end
                case (grant_s)
                    GNT_ALU: begin
                        cdb_valid_r <= True;
                        cdb_src_r   <= CDB_SRC_ALU;
                        cdb_rob_r   <= win_s[W-1:DATA_W];
                        cdb_value_r <= win_s[DATA_W-1:0];
                    end
                    GNT_LSB: begin
                        cdb_valid_r <= True;
                        cdb_src_r   <= CDB_SRC_LSB;
                        cdb_rob_r   <= win_s[W-1:DATA_W];
                        cdb_value_r <= win_s[DATA_W-1:0];
                    end
                    default: cdb_valid_r <= False;
                endcase
            end
        end
    end

    // Sticky protocol-error flag; survives flush, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= False;
        end else if (rdy && ovf_set_s) begin
            overflow_r <= True;
        end
    end

    assign cdb_valid = cdb_valid_r;
    assign cdb_src   = cdb_src_r;
    assign cdb_rob   = cdb_rob_r;
    assign cdb_value = cdb_value_r;
    assign overflow  = overflow_r;
    assign alu_full  = alu_full_s;
    assign lsb_full  = lsb_full_s;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares one registered common data bus (CDB) between the two result producers, ALU and LSB, so reservation stations, LSB and ROB snoop a single broadcast.
- Per-source skid FIFO absorbs the loser of a same-cycle collision.
- Fair round-robin grant between the sources.
- Flushed by `clr` on mispredict.

Parameters:
ROB_W, 4, ROB tag width (matches ROBBus)
DATA_W, 32, result value width (matches DataBus)
FIFO_DEPTH, 4, entries per source FIFO (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global enable; low = freeze all state
clr  in  1  synchronous flush (mispredict)
alu_valid  in  1  ALU result valid this cycle
alu_rob  in  ROB_W  ALU result ROB tag
alu_value  in  DATA_W  ALU result value
alu_full  out  1  ALU FIFO count == FIFO_DEPTH; RS must not issue
lsb_valid  in  1  LSB result valid this cycle
lsb_rob  in  ROB_W  LSB result ROB tag
lsb_value  in  DATA_W  LSB result value
lsb_full  out  1  LSB FIFO count == FIFO_DEPTH; LSB must not complete
cdb_valid  out  1  broadcast valid (registered)
cdb_src  out  1  0 = ALU, 1 = LSB
cdb_rob  out  ROB_W  broadcast tag
cdb_value  out  DATA_W  broadcast value
overflow  out  1  sticky: push attempted while FIFO full

Behaviour:
- Reset (async, any time):
  - cdb_valid/src/rob/value = 0; alu_full = lsb_full = 0; overflow = 0.
  - Both FIFOs empty; round-robin pointer rr = 0 (ALU preferred).
- rdy low: every register holds, inputs ignored, outputs unchanged.
- clr high (rdy high), next edge:
  - FIFOs emptied, cdb_valid = 0, rr = 0.
  - Same-cycle inputs discarded.
  - overflow not cleared.
- Candidate per source:
  - FIFO non-empty: its head.
  - Else, if x_valid: the live input (bypass).
  - A live input never overtakes its own FIFO contents; per-source order is preserved.
- Grant:
  - Neither candidate: cdb_valid <= 0 at the edge.
  - One candidate: that source is granted.
  - Both candidates: source rr is granted, then rr flips.
  - rr changes only on contention.
- Granted entry is loaded into the cdb_* registers at the edge, with cdb_valid = 1, and held exactly one cycle unless regranted.
- Latency:
  - Uncontended input sampled at edge E is on the CDB for the cycle after E. Zero extra latency.
  - A queued entry waits one cycle per earlier entry it loses to.
- Enqueue: a live x_valid that is not consumed by bypass is pushed to FIFO x.
  - Push accepted only if count < FIFO_DEPTH at that edge.
  - Otherwise the entry is dropped and overflow <= 1. This is a protocol error; the bench must flag it.
- Same-edge pop + push on one FIFO: head leaves, new entry enters the tail, count unchanged.
- Pointer wrap: read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits.
- x_full is a registered decode of count == FIFO_DEPTH. Producers sample it before issuing, so one-cycle visibility is acceptable.
- No tag checking: the arbiter passes ROB tags through unmodified.

Decomposition:
- Shared package (header defines): ROB_W/DATA_W aliases of ROBBus/DataBus, CDB_SRC_ALU = 0, CDB_SRC_LSB = 1, Enable/Disable, True/False.
- One sub-module, cdb_fifo: parameterised FIFO with push, pop, flush, head, count and full. Instantiated twice, once for ALU and once for LSB.
- Arbitration and output registers stay in cdb_arbiter.

Test Plan:
1. ALU only: alu_valid=1, rob=3, value=0x0000_00AA at edge E -> next cycle cdb_valid=1, src=0, rob=3, value=0xAA; the cycle after, cdb_valid=0.
2. Collision: ALU (rob 1, 0x11) and LSB (rob 2, 0x22) same edge, rr=0 -> CDB shows ALU/1 then LSB/2 on consecutive cycles. A second collision (rob 5 ALU, rob 6 LSB) -> LSB/6 first, then ALU/5.
3. Backpressure: LSB valid every cycle while ALU valid every cycle with DEPTH=4 -> each source alternates. With LSB issuing 5 extra entries during ALU priority, lsb_full=1 once count hits 4. One more push -> overflow=1 and that entry is never broadcast.
4. Flush: 3 ALU entries queued, clr pulsed one cycle -> next cycle cdb_valid=0, alu_full=0. A fresh ALU result (rob 7) two cycles later appears with one-cycle latency.
5. Stall: rdy=0 for 3 cycles while CDB shows rob 4 and one LSB entry is queued -> cdb outputs frozen on rob 4, no pop. After rdy=1, the queued LSB entry appears next cycle.
6. Async reset: assert rst between edges with cdb_valid=1 and both FIFOs non-empty -> outputs 0 immediately, without waiting for an edge. After release, the first input follows scenario 1 timing.
